hazard_scoreboard: RTL and testbench

- Issue-side controller for the decode stage of the vector ASIP pipeline.
- Tracks in-flight destination registers separately for the scalar register file (16x32) and the vector register file (16x128).
- Stalls decode on read-after-write hazards; there is no forwarding path.
- Runs the squash sequence after a taken jump and drives the writeback slot information (valid/VF/dest) used to select the write-enabled register file.

---
 rtl/hazard_scoreboard.sv | 200 ++++++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: pending-write counters for the scalar and vector
// register files, RAW stall, taken-jump squash sequencing and the writeback slot.
module hazard_scoreboard #(
    parameter int NREGS = 16,
    parameter int RW    = 4,
    parameter int DEPTH = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             dec_valid_i,
    input  logic             dec_wreg_i,
    input  logic             dec_vf_i,
    input  logic [RW-1:0]    dec_dest_i,
    input  logic             src_vf_i,
    input  logic             use_s2_i,
    input  logic             use_s3_i,
    input  logic [RW-1:0]    src2_i,
    input  logic [RW-1:0]    src3_i,
    input  logic             jmp_taken_i,
    output logic             stall_o,
    output logic             flush_o,
    output logic             issue_o,
    output logic             wb_valid_o,
    output logic             wb_vf_o,
    output logic [RW-1:0]    wb_dest_o,
    output logic [NREGS-1:0] busy_s_o,
    output logic [NREGS-1:0] busy_v_o
);

    localparam int            CW       = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    // state | meaning
    // RUN   | normal issue, RAW hazards stall decode
    // SQ1   | second flush cycle after a taken jump
    // SQ2   | fetch refill cycle, nothing issues
    typedef enum logic [1:0] {
        RUN = 2'd0,
        SQ1 = 2'd1,
        SQ2 = 2'd2
    } state_t;

    typedef struct packed {
        logic          valid;
        logic          wreg;
        logic          vf;
        logic [RW-1:0] dest;
    } slot_t;

    state_t        state_q, state_d;
    slot_t         slot_q  [DEPTH];
    slot_t         slot_d  [DEPTH];
    logic [CW-1:0] cnt_s_q [NREGS];
    logic [CW-1:0] cnt_s_d [NREGS];
    logic [CW-1:0] cnt_v_q [NREGS];
    logic [CW-1:0] cnt_v_d [NREGS];
    logic          hold_q;

    logic             out_en;
    slot_t            ret;
    logic             ret_wr;
    logic             inc_wr;
    logic [NREGS-1:0] pend_s;
    logic [NREGS-1:0] pend_v;
    logic [NREGS-1:0] pend_src;
    logic [CW-1:0]    dest_cnt;
    logic             ret_same;
    logic             haz_src;
    logic             haz_full;
    logic             haz;

    function automatic logic [CW-1:0] next_cnt(input logic [CW-1:0] cur,
                                               input logic          inc,
                                               input logic          dec);
        if (inc && !dec) return cur + CW'(1);
        if (dec && !inc) return cur - CW'(1);
        return cur;
    endfunction

    // Decode control is held off in the reset cycle and the cycle after it.
    always_ff @(posedge clk_i) begin
        hold_q <= rst_i;
    end

    assign out_en = ~rst_i & ~hold_q;

    assign ret    = slot_q[DEPTH-1];
    assign ret_wr = ret.valid & ret.wreg;
    assign inc_wr = issue_o & dec_wreg_i;

    always_comb begin
        pend_s = '0;
        pend_v = '0;
        for (int i = 0; i < NREGS; i++) begin
            pend_s[i] = (cnt_s_q[i] != '0);
            pend_v[i] = (cnt_v_q[i] != '0);
        end
    end

    // A retiring register is still busy: the register file only updates on the edge.
    assign pend_src = src_vf_i ? pend_v : pend_s;
    assign haz_src  = (use_s2_i & pend_src[src2_i]) | (use_s3_i & pend_src[src3_i]);

    assign dest_cnt = dec_vf_i ? cnt_v_q[dec_dest_i] : cnt_s_q[dec_dest_i];
    assign ret_same = ret_wr & (ret.vf == dec_vf_i) & (ret.dest == dec_dest_i);
    assign haz_full = dec_wreg_i & (dest_cnt == CNT_FULL) & ~ret_same;
    assign haz      = haz_src | haz_full;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (jmp_taken_i && out_en) state_d = SQ1;
            SQ1:     state_d = SQ2;
            SQ2:     state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        issue_o = 1'b0;
        stall_o = 1'b0;
        flush_o = 1'b0;
        if (out_en) begin
            case (state_q)
                RUN: begin
                    flush_o = jmp_taken_i;
                    issue_o = dec_valid_i & ~haz & ~jmp_taken_i;
                    stall_o = dec_valid_i &  haz & ~jmp_taken_i;
                end
                SQ1:     flush_o = 1'b1;
                default: flush_o = 1'b0;
            endcase
        end
    end

    always_comb begin
        slot_d[0] = '0;
        if (issue_o) begin
            slot_d[0] = {1'b1, dec_wreg_i, dec_vf_i, dec_dest_i};
        end
        for (int i = 1; i < DEPTH; i++) begin
            slot_d[i] = slot_q[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) slot_q[i] <= slot_d[i];
        end
    end

    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            cnt_s_d[i] = next_cnt(cnt_s_q[i],
                                  inc_wr & ~dec_vf_i & (dec_dest_i == RW'(i)),
                                  ret_wr & ~ret.vf   & (ret.dest   == RW'(i)));
            cnt_v_d[i] = next_cnt(cnt_v_q[i],
                                  inc_wr &  dec_vf_i & (dec_dest_i == RW'(i)),
                                  ret_wr &  ret.vf   & (ret.dest   == RW'(i)));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREGS; i++) begin
                cnt_s_q[i] <= '0;
                cnt_v_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                cnt_s_q[i] <= cnt_s_d[i];
                cnt_v_q[i] <= cnt_v_d[i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && ret_wr) begin
            assert ((ret.vf ? cnt_v_q[ret.dest] : cnt_s_q[ret.dest]) != '0)
                else $error("scoreboard counter underflow on retire");
        end
    end

    assign wb_valid_o = ~rst_i & ret_wr;
    assign wb_vf_o    = ~rst_i & ret.vf;
    assign wb_dest_o  = rst_i ? '0 : ret.dest;
    assign busy_s_o   = rst_i ? '0 : pend_s;
    assign busy_v_o   = rst_i ? '0 : pend_v;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: one table row per clock cycle with
// hand-computed outputs, followed by two bounded multi-cycle sequences.
module tb_hazard_scoreboard;

    localparam int NREGS = 16;
    localparam int RW    = 4;
    localparam int DEPTH = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             dec_valid, dec_wreg, dec_vf;
    logic [RW-1:0]    dec_dest;
    logic             src_vf, use_s2, use_s3;
    logic [RW-1:0]    src2, src3;
    logic             jmp_taken;
    logic             stall, flush, issue, wb_valid, wb_vf;
    logic [RW-1:0]    wb_dest;
    logic [NREGS-1:0] busy_s, busy_v;

    always #5 clk = ~clk;

    hazard_scoreboard #(.NREGS(NREGS), .RW(RW), .DEPTH(DEPTH)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .dec_valid_i(dec_valid),
        .dec_wreg_i (dec_wreg),
        .dec_vf_i   (dec_vf),
        .dec_dest_i (dec_dest),
        .src_vf_i   (src_vf),
        .use_s2_i   (use_s2),
        .use_s3_i   (use_s3),
        .src2_i     (src2),
        .src3_i     (src3),
        .jmp_taken_i(jmp_taken),
        .stall_o    (stall),
        .flush_o    (flush),
        .issue_o    (issue),
        .wb_valid_o (wb_valid),
        .wb_vf_o    (wb_vf),
        .wb_dest_o  (wb_dest),
        .busy_s_o   (busy_s),
        .busy_v_o   (busy_v)
    );

    typedef struct {
        logic        r, dv, wr, dvf;
        logic [3:0]  dst;
        logic        svf, u2, u3;
        logic [3:0]  s2, s3;
        logic        j;
        logic        e_st, e_fl, e_is, e_wv, e_wvf;
        logic [3:0]  e_wd;
        logic [15:0] e_bs, e_bv;
    } vec_t;

    vec_t tv[$];
    int   errors = 0;
    int   checks = 0;

    function automatic void add(int r, int dv, int wr, int dvf, int dst,
                                int svf, int u2, int u3, int s2, int s3, int j,
                                int st, int fl, int is, int wv, int wvf, int wd,
                                int bs, int bv);
        vec_t v;
        v.r = r[0]; v.dv = dv[0]; v.wr = wr[0]; v.dvf = dvf[0]; v.dst = dst[3:0];
        v.svf = svf[0]; v.u2 = u2[0]; v.u3 = u3[0]; v.s2 = s2[3:0]; v.s3 = s3[3:0];
        v.j = j[0];
        v.e_st = st[0]; v.e_fl = fl[0]; v.e_is = is[0]; v.e_wv = wv[0];
        v.e_wvf = wvf[0]; v.e_wd = wd[3:0]; v.e_bs = bs[15:0]; v.e_bv = bv[15:0];
        tv.push_back(v);
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst = v.r; dec_valid = v.dv; dec_wreg = v.wr; dec_vf = v.dvf; dec_dest = v.dst;
        src_vf = v.svf; use_s2 = v.u2; use_s3 = v.u3; src2 = v.s2; src3 = v.s3;
        jmp_taken = v.j;
    endtask

    task automatic idle();
        rst = 1'b0; dec_valid = 1'b0; dec_wreg = 1'b0; dec_vf = 1'b0; dec_dest = '0;
        src_vf = 1'b0; use_s2 = 1'b0; use_s3 = 1'b0; src2 = '0; src3 = '0;
        jmp_taken = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int stalls, wb_at, cyc, flushes;
        bit done;
        idle();
        rst = 1'b1;

        //  r dv wr dvf dst svf u2 u3 s2 s3 j | st fl is wv wvf wd  busy_s busy_v
        // reset cycle, then post-reset cycle, then scalar RAW on r5
        add(1, 1, 1, 0, 5,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 'h0000, 'h0000);
        add(0, 1, 1, 0, 5,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 'h0000, 'h0000);
        add(0, 1, 1, 0, 5,  0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 'h0000, 'h0000);
        add(0, 1, 0, 0, 0,  0, 1, 0, 5, 0, 0,  1, 0, 0, 0, 0, 0, 'h0020, 'h0000);
        add(0, 1, 0, 0, 0,  0, 1, 0, 5, 0, 0,  1, 0, 0, 0, 0, 0, 'h0020, 'h0000);
        add(0, 1, 0, 0, 0,  0, 1, 0, 5, 0, 0,  1, 0, 0, 1, 0, 5, 'h0020, 'h0000);
        add(0, 1, 0, 0, 0,  0, 1, 0, 5, 0, 0,  0, 0, 1, 0, 0, 0, 'h0000, 'h0000);
        // independent ops r1..r3 reading r7/r8
        add(0, 1, 1, 0, 1,  0, 1, 1, 7, 8, 0,  0, 0, 1, 0, 0, 0, 'h0000, 'h0000);
        add(0, 1, 1, 0, 2,  0, 1, 1, 7, 8, 0,  0, 0, 1, 0, 0, 0, 'h0002, 'h0000);
        add(0, 1, 1, 0, 3,  0, 1, 1, 7, 8, 0,  0, 0, 1, 0, 0, 0, 'h0006, 'h0000);
        add(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 1, 'h000E, 'h0000);
        add(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 2, 'h000C, 'h0000);
        add(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 3, 'h0008, 'h0000);
        add(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 'h0000, 'h0000);
        // file separation: vector v4 write, scalar r4 read, vector v4 read
        add(0, 1, 1, 1, 4,  0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 'h0000, 'h0000);
        add(0, 1, 0, 0, 0,  0, 0, 1, 0, 4, 0,  0, 0, 1, 0, 0, 0, 'h0000, 'h0010);
        add(0, 1, 0, 0, 0,  1, 1, 0, 4, 0, 0,  1, 0, 0, 0, 0, 0, 'h0000, 'h0010);
        add(0, 1, 0, 0, 0,  1, 1, 0, 4, 0, 0,  1, 0, 0, 1, 1, 4, 'h0000, 'h0010);
        add(0, 1, 0, 0, 0,  1, 1, 0, 4, 0, 0,  0, 0, 1, 0, 0, 0, 'h0000, 'h0000);
        // four writes to r6; the fourth lands while the first retires
        add(0, 1, 1, 0, 6,  0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 'h0000, 'h0000);
        add(0, 1, 1, 0, 6,  0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 'h0040, 'h0000);
        add(0, 1, 1, 0, 6,  0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 'h0040, 'h0000);
        add(0, 1, 1, 0, 6,  0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 6, 'h0040, 'h0000);
        add(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 6, 'h0040, 'h0000);
        add(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 6, 'h0040, 'h0000);
        add(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 6, 'h0040, 'h0000);
        add(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 'h0000, 'h0000);
        // taken jump behind an older r9 write; jumps during squash ignored
        add(0, 1, 1, 0, 9,  0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 'h0000, 'h0000);
        add(0, 1, 1, 0, 10, 0, 0, 0, 0, 0, 1,  0, 1, 0, 0, 0, 0, 'h0200, 'h0000);
        add(0, 1, 0, 0, 0,  0, 1, 0, 9, 0, 1,  0, 1, 0, 0, 0, 0, 'h0200, 'h0000);
        add(0, 1, 0, 0, 0,  0, 1, 0, 9, 0, 1,  0, 0, 0, 1, 0, 9, 'h0200, 'h0000);
        add(0, 1, 1, 0, 10, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 'h0000, 'h0000);
        // reset during a stall with two writes in flight
        add(0, 1, 1, 0, 11, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 'h0400, 'h0000);
        add(0, 1, 0, 0, 0,  0, 1, 0, 11, 0, 0, 1, 0, 0, 0, 0, 0, 'h0C00, 'h0000);
        add(1, 1, 0, 0, 0,  0, 1, 0, 11, 0, 0, 0, 0, 0, 0, 0, 0, 'h0000, 'h0000);
        add(0, 1, 0, 0, 0,  0, 1, 0, 11, 0, 0, 0, 0, 0, 0, 0, 0, 'h0000, 'h0000);
        add(0, 1, 0, 0, 0,  0, 1, 0, 11, 0, 0, 0, 0, 1, 0, 0, 0, 'h0000, 'h0000);
        add(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 'h0000, 'h0000);
        add(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 'h0000, 'h0000);

        foreach (tv[k]) begin
            @(posedge clk);
            #1;
            drive(tv[k]);
            @(negedge clk);
            check("stall",    k, 32'(stall),    32'(tv[k].e_st));
            check("flush",    k, 32'(flush),    32'(tv[k].e_fl));
            check("issue",    k, 32'(issue),    32'(tv[k].e_is));
            check("wb_valid", k, 32'(wb_valid), 32'(tv[k].e_wv));
            check("wb_vf",    k, 32'(wb_vf),    32'(tv[k].e_wvf));
            check("wb_dest",  k, 32'(wb_dest),  32'(tv[k].e_wd));
            check("busy_s",   k, 32'(busy_s),   32'(tv[k].e_bs));
            check("busy_v",   k, 32'(busy_v),   32'(tv[k].e_bv));
        end

        // Vector RAW through source 3: dependent stalls DEPTH cycles, writeback
        // shows in the last stall cycle, issue follows on the next cycle.
        @(posedge clk); #1;
        idle();
        dec_valid = 1'b1; dec_wreg = 1'b1; dec_vf = 1'b1; dec_dest = 4'd7;
        @(negedge clk);
        check("vraw_first_issue", 100, 32'(issue), 32'd1);
        @(posedge clk); #1;
        idle();
        dec_valid = 1'b1; src_vf = 1'b1; use_s3 = 1'b1; src3 = 4'd7;
        stalls = 0; wb_at = -1; done = 1'b0; cyc = 0;
        while (!done && cyc < 10) begin
            @(negedge clk);
            if (wb_valid && wb_vf && wb_dest == 4'd7) wb_at = cyc;
            if (issue) done = 1'b1;
            else begin
                if (stall) stalls++;
                @(posedge clk); #1;
                cyc++;
            end
        end
        check("vraw_issue_seen",  101, 32'(done),   32'd1);
        check("vraw_stall_count", 102, 32'(stalls), 32'(DEPTH));
        check("vraw_wb_cycle",    103, 32'(wb_at),  32'(DEPTH - 1));

        // Jump with an empty decode slot still flushes for exactly two cycles.
        @(posedge clk); #1;
        idle();
        jmp_taken = 1'b1;
        flushes = 0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (flush) flushes++;
            if (n == 2) check("jmp_refill_issue", 104, 32'(issue | flush), 32'd0);
            @(posedge clk); #1;
            jmp_taken = (n < 2);
        end
        check("jmp_flush_cycles", 105, 32'(flushes), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
